// File: rtl/regfile_pkg.sv
// Shared widths, command opcodes and sequencer state encoding for the
// register-file bulk-access sequencer.
package regfile_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

   localparam logic OP_FILL = 1'b0;
   localparam logic OP_DUMP = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      DUMP_RD,
      DUMP_OUT,
      DONE
   } seq_state_t;

endpackage

// File: rtl/regfile_dump_buf.sv
// Holding register for one dump beat: loads a register pair on capture and
// keeps it stable until the consumer takes it.
module regfile_dump_buf #(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load,
   input  logic                  i_consume,
   input  logic [ADDR_WIDTH-1:0] i_index,
   input  logic [DATA_WIDTH-1:0] i_data_a,
   input  logic [DATA_WIDTH-1:0] i_data_b,
   output logic                  o_valid,
   output logic [ADDR_WIDTH-1:0] o_index,
   output logic [DATA_WIDTH-1:0] o_data_a,
   output logic [DATA_WIDTH-1:0] o_data_b
);

   logic                  r_valid;
   logic [ADDR_WIDTH-1:0] r_index;
   logic [DATA_WIDTH-1:0] r_data_a;
   logic [DATA_WIDTH-1:0] r_data_b;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid  <= 1'b0;
         r_index  <= '0;
         r_data_a <= '0;
         r_data_b <= '0;
      end else begin
         // A new capture wins over a consume; the FSM never asserts both.
         if (i_load) begin
            r_valid  <= 1'b1;
            r_index  <= i_index;
            r_data_a <= i_data_a;
            r_data_b <= i_data_b;
         end else if (i_consume) begin
            r_valid  <= 1'b0;
         end
      end
   end

   assign o_valid  = r_valid;
   assign o_index  = r_index;
   assign o_data_a = r_data_a;
   assign o_data_b = r_data_b;

endmodule

// File: rtl/regfile_sequencer.sv
// Bulk-access master for the register file: FILL writes seed+index into
// registers 1..31, DUMP streams all registers out as pairs with backpressure.
module regfile_sequencer #(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  ctrl_reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_seed,
   output logic                  rf_writeEnable,
   output logic [ADDR_WIDTH-1:0] rf_writeReg,
   output logic [DATA_WIDTH-1:0] rf_writeData,
   output logic [ADDR_WIDTH-1:0] rf_readRegA,
   output logic [ADDR_WIDTH-1:0] rf_readRegB,
   input  logic [DATA_WIDTH-1:0] rf_readDataA,
   input  logic [DATA_WIDTH-1:0] rf_readDataB,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [ADDR_WIDTH-1:0] dump_index,
   output logic [DATA_WIDTH-1:0] dump_dataA,
   output logic [DATA_WIDTH-1:0] dump_dataB,
   output logic                  busy,
   output logic                  done
);

   import regfile_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] LP_ONE       = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] LP_TWO       = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] LP_LAST_FILL = '1;
   localparam logic [ADDR_WIDTH-1:0] LP_LAST_PAIR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

   seq_state_t            r_state;
   seq_state_t            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;
   logic [DATA_WIDTH-1:0] r_seed;
   logic [DATA_WIDTH-1:0] w_seed_nxt;
   logic                  w_capture;
   logic                  w_beat_acc;

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_seed  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_seed  <= w_seed_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_seed_nxt     = r_seed;
      w_capture      = 1'b0;
      w_beat_acc     = 1'b0;
      cmd_ready      = 1'b0;
      done           = 1'b0;
      rf_writeEnable = 1'b0;
      rf_writeReg    = '0;
      rf_writeData   = '0;
      rf_readRegA    = '0;
      rf_readRegB    = '0;

      case (r_state)
         IDLE: begin
            // Gated by reset so the command port reads as not-ready while held.
            cmd_ready = ctrl_reset_n;
            if (cmd_valid) begin
               w_seed_nxt = cmd_seed;
               if (cmd_op == OP_DUMP) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = DUMP_RD;
               end else begin
                  w_cnt_nxt   = LP_ONE;
                  w_state_nxt = FILL;
               end
            end
         end

         FILL: begin
            rf_writeEnable = 1'b1;
            rf_writeReg    = r_cnt;
            rf_writeData   = r_seed + DATA_WIDTH'(r_cnt);
            w_cnt_nxt      = r_cnt + LP_ONE;
            if (r_cnt == LP_LAST_FILL) begin
               w_state_nxt = DONE;
            end
         end

         DUMP_RD: begin
            rf_readRegA = r_cnt;
            rf_readRegB = r_cnt + LP_ONE;
            w_capture   = 1'b1;
            w_state_nxt = DUMP_OUT;
         end

         DUMP_OUT: begin
            if (dump_ready) begin
               w_beat_acc = 1'b1;
               if (r_cnt == LP_LAST_PAIR) begin
                  w_state_nxt = DONE;
               end else begin
                  w_cnt_nxt   = r_cnt + LP_TWO;
                  w_state_nxt = DUMP_RD;
               end
            end
         end

         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (r_state != IDLE);

   regfile_dump_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dump_buf (
      .i_clk     (clock),
      .i_rst_n   (ctrl_reset_n),
      .i_load    (w_capture),
      .i_consume (w_beat_acc),
      .i_index   (r_cnt),
      .i_data_a  (rf_readDataA),
      .i_data_b  (rf_readDataB),
      .o_valid   (dump_valid),
      .o_index   (dump_index),
      .o_data_a  (dump_dataA),
      .o_data_b  (dump_dataB)
   );

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 32x32 register file
// on its far side; expected beats and register contents are hand-computed.
module tb_regfile_sequencer;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] a;
      logic [31:0] b;
   } beat_t;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] v;
   } regchk_t;

   logic        clock        = 1'b0;
   logic        ctrl_reset_n = 1'b1;
   logic        cmd_valid    = 1'b0;
   logic        cmd_op       = 1'b0;
   logic [31:0] cmd_seed     = '0;
   logic        dump_ready   = 1'b0;
   logic        cmd_ready;
   logic        rf_writeEnable;
   logic [4:0]  rf_writeReg;
   logic [31:0] rf_writeData;
   logic [4:0]  rf_readRegA;
   logic [4:0]  rf_readRegB;
   logic [31:0] rf_readDataA;
   logic [31:0] rf_readDataB;
   logic        dump_valid;
   logic [4:0]  dump_index;
   logic [31:0] dump_dataA;
   logic [31:0] dump_dataB;
   logic        busy;
   logic        done;

   logic [31:0] rf_mem [32] = '{default: 32'hDEAD_BEEF};
   logic        reg0_written = 1'b0;
   int          n_writes = 0;
   int          n_beats  = 0;
   int          checks   = 0;
   int          errors   = 0;

   beat_t   beats    [16];
   regchk_t fill_tbl [4];
   regchk_t rst_tbl  [4];

   always #5 clock = ~clock;

   regfile_sequencer #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5)
   ) dut (
      .clock          (clock),
      .ctrl_reset_n   (ctrl_reset_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_seed       (cmd_seed),
      .rf_writeEnable (rf_writeEnable),
      .rf_writeReg    (rf_writeReg),
      .rf_writeData   (rf_writeData),
      .rf_readRegA    (rf_readRegA),
      .rf_readRegB    (rf_readRegB),
      .rf_readDataA   (rf_readDataA),
      .rf_readDataB   (rf_readDataB),
      .dump_valid     (dump_valid),
      .dump_ready     (dump_ready),
      .dump_index     (dump_index),
      .dump_dataA     (dump_dataA),
      .dump_dataB     (dump_dataB),
      .busy           (busy),
      .done           (done)
   );

   // Register file model: register 0 reads as zero, reads are combinational.
   assign rf_readDataA = (rf_readRegA == 5'd0) ? 32'd0 : rf_mem[rf_readRegA];
   assign rf_readDataB = (rf_readRegB == 5'd0) ? 32'd0 : rf_mem[rf_readRegB];

   always @(posedge clock) begin
      if (rf_writeEnable) begin
         rf_mem[rf_writeReg] <= rf_writeData;
         n_writes <= n_writes + 1;
         if (rf_writeReg == 5'd0) reg0_written <= 1'b1;
      end
      if (dump_valid && dump_ready) n_beats <= n_beats + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_fill(input logic [31:0] seed, input bit inject);
      int w0;
      w0 = n_writes;
      cmd_valid = 1'b1;
      cmd_op    = 1'b0;
      cmd_seed  = seed;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clock);
         if (k == 1) cmd_valid = 1'b0;
         if (inject && k == 5) begin
            cmd_valid = 1'b1;
            cmd_op    = 1'b1;
         end
         if (inject && k == 20) cmd_valid = 1'b0;
         if (k <= 31) begin
            chk("fill_we",    32'(rf_writeEnable), 32'd1);
            chk("fill_reg",   32'(rf_writeReg), 32'(k));
            chk("fill_data",  rf_writeData, seed + 32'(k));
            chk("fill_ready", 32'(cmd_ready), 32'd0);
            chk("fill_done",  32'(done), 32'd0);
         end else if (k == 32) begin
            chk("done_we",    32'(rf_writeEnable), 32'd0);
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_ready", 32'(cmd_ready), 32'd0);
            chk("done_busy",  32'(busy), 32'd1);
         end else begin
            chk("after_done",  32'(done), 32'd0);
            chk("after_ready", 32'(cmd_ready), 32'd1);
            chk("after_busy",  32'(busy), 32'd0);
         end
      end
      chk("fill_nwrites", 32'(n_writes - w0), 32'd31);
   endtask

   task automatic check_beat(input int b);
      chk("beat_valid", 32'(dump_valid), 32'd1);
      chk("beat_index", 32'(dump_index), 32'(beats[b].idx));
      chk("beat_A",     dump_dataA, beats[b].a);
      chk("beat_B",     dump_dataB, beats[b].b);
      chk("out_addrA",  32'(rf_readRegA), 32'd0);
      chk("out_addrB",  32'(rf_readRegB), 32'd0);
   endtask

   task automatic run_dump(input int stall_beat);
      int b0;
      b0 = n_beats;
      cmd_valid  = 1'b1;
      cmd_op     = 1'b1;
      dump_ready = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      for (int b = 0; b < 16; b++) begin
         chk("rd_addrA",  32'(rf_readRegA), 32'(beats[b].idx));
         chk("rd_addrB",  32'(rf_readRegB), 32'(beats[b].idx) + 32'd1);
         chk("rd_valid0", 32'(dump_valid), 32'd0);
         if (b == stall_beat) dump_ready = 1'b0;
         @(negedge clock);
         check_beat(b);
         if (b == stall_beat) begin
            repeat (4) begin
               @(negedge clock);
               check_beat(b);
            end
            dump_ready = 1'b1;
         end
         @(negedge clock);
      end
      chk("dump_done",   32'(done), 32'd1);
      chk("dump_busy",   32'(busy), 32'd1);
      chk("dump_ready0", 32'(cmd_ready), 32'd0);
      chk("dump_vld0",   32'(dump_valid), 32'd0);
      @(negedge clock);
      chk("dump_done0",  32'(done), 32'd0);
      chk("dump_idle",   32'(cmd_ready), 32'd1);
      chk("dump_nbeats", 32'(n_beats - b0), 32'd16);
   endtask

   initial begin
      int w0;

      beats[0]  = '{5'd0,  32'h0000_0000, 32'hFFFF_FFF1};
      beats[1]  = '{5'd2,  32'hFFFF_FFF2, 32'hFFFF_FFF3};
      beats[2]  = '{5'd4,  32'hFFFF_FFF4, 32'hFFFF_FFF5};
      beats[3]  = '{5'd6,  32'hFFFF_FFF6, 32'hFFFF_FFF7};
      beats[4]  = '{5'd8,  32'hFFFF_FFF8, 32'hFFFF_FFF9};
      beats[5]  = '{5'd10, 32'hFFFF_FFFA, 32'hFFFF_FFFB};
      beats[6]  = '{5'd12, 32'hFFFF_FFFC, 32'hFFFF_FFFD};
      beats[7]  = '{5'd14, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      beats[8]  = '{5'd16, 32'h0000_0000, 32'h0000_0001};
      beats[9]  = '{5'd18, 32'h0000_0002, 32'h0000_0003};
      beats[10] = '{5'd20, 32'h0000_0004, 32'h0000_0005};
      beats[11] = '{5'd22, 32'h0000_0006, 32'h0000_0007};
      beats[12] = '{5'd24, 32'h0000_0008, 32'h0000_0009};
      beats[13] = '{5'd26, 32'h0000_000A, 32'h0000_000B};
      beats[14] = '{5'd28, 32'h0000_000C, 32'h0000_000D};
      beats[15] = '{5'd30, 32'h0000_000E, 32'h0000_000F};

      fill_tbl[0] = '{5'd1,  32'hFFFF_FFF1};
      fill_tbl[1] = '{5'd15, 32'hFFFF_FFFF};
      fill_tbl[2] = '{5'd16, 32'h0000_0000};
      fill_tbl[3] = '{5'd31, 32'h0000_000F};

      rst_tbl[0] = '{5'd9,  32'h1000_0009};
      rst_tbl[1] = '{5'd10, 32'hFFFF_FFFA};
      rst_tbl[2] = '{5'd11, 32'hFFFF_FFFB};
      rst_tbl[3] = '{5'd31, 32'h0000_000F};

      // Reset held: inputs wiggle, every output stays at zero.
      #1 ctrl_reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         cmd_valid  = ~cmd_valid;
         cmd_op     = ~cmd_op;
         cmd_seed   = cmd_seed ^ 32'h5A5A_A5A5;
         dump_ready = ~dump_ready;
      end
      #1;
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_we",    32'(rf_writeEnable), 32'd0);
      chk("rst_wreg",  32'(rf_writeReg), 32'd0);
      chk("rst_wdata", rf_writeData, 32'd0);
      chk("rst_raddr", 32'({rf_readRegA, rf_readRegB}), 32'd0);
      chk("rst_valid", 32'(dump_valid), 32'd0);
      chk("rst_index", 32'(dump_index), 32'd0);
      chk("rst_dataA", dump_dataA, 32'd0);
      chk("rst_dataB", dump_dataB, 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);

      @(negedge clock);
      cmd_valid    = 1'b0;
      cmd_op       = 1'b0;
      dump_ready   = 1'b0;
      ctrl_reset_n = 1'b1;
      #1;
      chk("rel_ready", 32'(cmd_ready), 32'd1);
      chk("rel_busy",  32'(busy), 32'd0);

      // FILL with a DUMP request offered (and ignored) part-way through.
      run_fill(32'hFFFF_FFF0, 1'b1);
      for (int i = 0; i < 4; i++)
         chk("fill_reg_val", rf_mem[fill_tbl[i].r], fill_tbl[i].v);
      chk("reg0_untouched", 32'(reg0_written), 32'd0);

      run_dump(-1);
      run_dump(3);

      // Reset during the cycle that would write register 10.
      w0 = n_writes;
      cmd_valid = 1'b1;
      cmd_op    = 1'b0;
      cmd_seed  = 32'h1000_0000;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         if (k == 1) cmd_valid = 1'b0;
      end
      chk("mid_we",  32'(rf_writeEnable), 32'd1);
      chk("mid_reg", 32'(rf_writeReg), 32'd10);
      #1 ctrl_reset_n = 1'b0;
      #1;
      chk("mid_rst_we",   32'(rf_writeEnable), 32'd0);
      chk("mid_rst_wreg", 32'(rf_writeReg), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clock);
      chk("mid_nwrites", 32'(n_writes - w0), 32'd9);
      for (int i = 0; i < 4; i++)
         chk("mid_reg_val", rf_mem[rst_tbl[i].r], rst_tbl[i].v);
      ctrl_reset_n = 1'b1;
      #1;
      chk("mid_rel_ready", 32'(cmd_ready), 32'd1);
      run_fill(32'h2000_0000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Bulk-access master for the 32 x 32-bit register file: it drives the regfile's write port and both read ports on behalf of a command interface. A FILL command writes a deterministic pattern into registers 1..31. A DUMP command streams all 32 registers out as 16 register pairs over a valid/ready interface with backpressure. The block sits beside the regfile, on the opposite side of its ports, and is used for bring-up, self-test and debug readout.

## Interface
Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width (NUM_REGS = 2**ADDR_WIDTH = 32)

Ports:
- clock  in  1  single clock; all state changes on rising edge
- ctrl_reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = FILL, 1 = DUMP
- cmd_seed  in  DATA_WIDTH  FILL base value; sampled at command accept
- rf_writeEnable  out  1  to regfile ctrl_writeEnable
- rf_writeReg  out  ADDR_WIDTH  to regfile ctrl_writeReg
- rf_writeData  out  DATA_WIDTH  to regfile data_writeReg
- rf_readRegA / rf_readRegB  out  ADDR_WIDTH  to regfile read selects
- rf_readDataA / rf_readDataB  in  DATA_WIDTH  from regfile; combinational, same cycle as address
- dump_valid  out  1  dump beat available
- dump_ready  in  1  consumer accepts beat
- dump_index  out  ADDR_WIDTH  even register index of the beat (A = index, B = index + 1)
- dump_dataA / dump_dataB  out  DATA_WIDTH  captured register contents
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE, FILL, DUMP_RD, DUMP_OUT, DONE. Counter cnt is ADDR_WIDTH bits; seed register is DATA_WIDTH bits.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_seed.
  - FILL: cnt = 1, go to FILL.
  - DUMP: cnt = 0, go to DUMP_RD.
- FILL:
  - rf_writeEnable = 1, rf_writeReg = cnt, rf_writeData = seed + cnt. The add is modulo 2**DATA_WIDTH with cnt zero-extended.
  - cnt increments each cycle. After the cycle with cnt = 31, go to DONE. Register 0 is never written.
- DUMP_RD:
  - rf_readRegA = cnt, rf_readRegB = cnt + 1.
  - At the edge, capture rf_readDataA/B into dump_dataA/B and cnt into dump_index, then go to DUMP_OUT.
- DUMP_OUT:
  - dump_valid = 1; dump outputs are held stable.
  - On dump_valid & dump_ready: if cnt = 30, go to DONE; otherwise cnt += 2 and go to DUMP_RD.
  - Without dump_ready, the block stalls indefinitely with no address change.
- DONE: done = 1, busy = 1, cmd_ready = 0. Next state is IDLE.
- rf_* outputs are decoded from state and counter. Outside their active states, rf_writeEnable = 0 and all addresses and data are 0.
- cmd_valid outside IDLE is ignored; no queuing.
- dump_ready outside DUMP_OUT is ignored.

## Timing
- Reset values (asserted asynchronously, no clock needed):
  - state IDLE, cnt 0, seed 0.
  - dump_valid 0, dump_index 0, dump_dataA/B 0.
  - rf_writeEnable 0, busy 0, done 0.
  - cmd_ready 1 once reset is released.
- Reset mid-operation: rf_writeEnable drops immediately and no further writes occur. Registers already written keep their values (the regfile's own reset is separate). A pending dump beat is discarded.
- FILL, with the command accepted at edge E0:
  - Writes occur at edges E1..E31.
  - done is high in cycle 32.
  - cmd_ready is high again in cycle 33.
- DUMP:
  - Addresses are driven in the cycle after accept; dump_valid rises one cycle later.
  - With dump_ready held high, there is one beat every 2 cycles: 16 beats in 32 cycles, then one DONE cycle.
- A FILL immediately followed by a DUMP reads the new values, because the regfile write is complete at the write edge.

## Structure
- Shared package regfile_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REGS
  - OP_FILL = 0, OP_DUMP = 1
  - the state encoding (IDLE, FILL, DUMP_RD, DUMP_OUT, DONE)
- One sub-module, regfile_dump_buf: the load-enabled output holding register for dump_index/dump_dataA/dump_dataB/dump_valid, with asynchronous active-low clear.
- The FSM and counter live in the top module.

## Test plan
- Reset: hold ctrl_reset_n low, toggle inputs -> all outputs 0. After release, cmd_ready = 1 and busy = 0.
- FILL with seed 0xFFFF_FFF0:
  - Exactly 31 write cycles, in order: reg1 = 0xFFFF_FFF1, reg15 = 0xFFFF_FFFF, reg16 = 0x0000_0000 (wrap), reg31 = 0x0000_000F.
  - Register 0 is never written.
  - done pulses once, in cycle 32.
- DUMP after that FILL, dump_ready held at 1:
  - 16 beats, 2 cycles apart.
  - Beat 0: index 0, A = 0, B = 0xFFFF_FFF1.
  - Beat 15: index 30, A = 0x0000_000E, B = 0x0000_000F.
- Backpressure: hold dump_ready = 0 for 5 cycles on beat 3 -> dump_index = 6 and data stay stable, rf_readRegA/B = 0, no beat lost or duplicated.
- Ignored commands: cmd_valid with op = DUMP during a FILL -> not accepted, FILL unaffected, cmd_ready low until IDLE.
- Reset mid-FILL: assert ctrl_reset_n low while writing reg 10 -> rf_writeEnable = 0 immediately, regs 11..31 keep their prior values. A new FILL after release restarts at reg 1.
